// File: rtl/alu_seq_pkg.sv
// Shared definitions for the DE2 ALU button sequencer.
//   state_e       : sequencer FSM states (also driven out on state_o)
//   edit_field_e  : display blink selector codes
//   KEY_*         : indices of the buttons that are actually used
//   edit_field_of : maps an FSM state to the field being edited
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    EF_OP   = 2'd0,
    EF_A    = 2'd1,
    EF_B    = 2'd2,
    EF_NONE = 2'd3
  } edit_field_e;

  localparam int KEY_INC   = 0;
  localparam int KEY_NEXT  = 1;
  localparam int KEY_ABORT = 2;
  localparam int NUM_KEYS  = 3;

  function automatic edit_field_e edit_field_of(state_e s);
    case (s)
      S_OP:    return EF_OP;
      S_A:     return EF_A;
      S_B:     return EF_B;
      default: return EF_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Operand/op/result bus between the sequencer and the 8-bit ALU.
//   alu_a, alu_b : operands       (sequencer -> ALU)
//   alu_op       : op code        (sequencer -> ALU)
//   alu_start    : start pulse    (sequencer -> ALU)
//   alu_result   : result         (ALU -> sequencer)
interface alu_sequencer_if;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic       alu_start;
  logic [7:0] alu_result;

  modport master (
    output alu_a, alu_b, alu_op, alu_start,
    input  alu_result
  );

  modport slave (
    input  alu_a, alu_b, alu_op, alu_start,
    output alu_result
  );
endinterface

// File: rtl/key_debounce.sv
// Debouncer for one active-low push button.
//   clk_i   : system clock
//   rst_ni  : synchronous reset, active-low
//   key_ni  : raw button level (0 = pressed), asynchronous
//   press_o : one-cycle pulse on an accepted press; releases produce nothing
// The raw level passes through a 2-FF synchronizer. A change is accepted once
// the synchronized level has differed from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // Reset to "released" so a key held across reset release is not a press
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        press_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_sequencer.sv
// Button-driven sequencer for the DE2 8-bit ALU.
//   CLOCK_50     : 50 MHz system clock
//   RESET_N      : synchronous reset, active-low
//   KEY[3:0]     : raw buttons, active-low; 0=inc, 1=next, 2=abort, 3 unused
//   alu          : ALU bus (operands, op, start pulse out; result in)
//   result_q     : latched ALU result
//   result_valid : result_q holds the current computation
//   edit_field   : field under edit (0=op, 1=A, 2=B, 3=none)
//   state_o      : current FSM state
//
// state  | meaning
// S_OP   | edit op code (inc steps alu_op)
// S_A    | edit operand A
// S_B    | edit operand B; next starts execution
// S_EXEC | waiting ALU_LATENCY cycles, then latch result
// S_SHOW | result displayed; next returns to S_OP
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int OP_COUNT        = 5,
  parameter int OPERAND_MAX     = 10,
  parameter int ALU_LATENCY     = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic [3:0]             KEY,
  alu_sequencer_if.master        alu,
  output logic [7:0]             result_q,
  output logic                   result_valid,
  output logic [1:0]             edit_field,
  output logic [2:0]             state_o
);

  localparam int LAT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(ALU_LATENCY - 1);
  localparam logic [3:0]       OP_LAST   = 4'(OP_COUNT - 1);
  localparam logic [7:0]       OPND_LAST = 8'(OPERAND_MAX);

  logic [NUM_KEYS-1:0] press;
  logic                unused_key3;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (CLOCK_50),
      .rst_ni (RESET_N),
      .key_ni (KEY[k]),
      .press_o(press[k])
    );
  end

  assign unused_key3 = KEY[3];

  // Same-cycle events: only the highest-priority one acts
  logic ev_abort;
  logic ev_next;
  logic ev_inc;

  assign ev_abort = press[KEY_ABORT];
  assign ev_next  = press[KEY_NEXT] & ~ev_abort;
  assign ev_inc   = press[KEY_INC] & ~press[KEY_NEXT] & ~ev_abort;

  state_e           state_q;
  logic [3:0]       op_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [7:0]       res_q;
  logic             valid_q;
  logic             start_q;
  logic [LAT_W-1:0] lat_q;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q <= S_OP;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      lat_q   <= '0;
    end else begin
      start_q <= 1'b0;
      if (ev_abort) begin
        // Operands and op survive an abort; a pending result is dropped
        state_q <= S_OP;
        valid_q <= 1'b0;
        lat_q   <= '0;
      end else begin
        case (state_q)
          S_OP: begin
            if (ev_next)     state_q <= S_A;
            else if (ev_inc) op_q <= (op_q == OP_LAST) ? '0 : op_q + 1'b1;
          end
          S_A: begin
            if (ev_next)     state_q <= S_B;
            else if (ev_inc) a_q <= (a_q == OPND_LAST) ? '0 : a_q + 1'b1;
          end
          S_B: begin
            if (ev_next) begin
              state_q <= S_EXEC;
              start_q <= 1'b1;
              valid_q <= 1'b0;
              lat_q   <= '0;
            end else if (ev_inc) begin
              b_q <= (b_q == OPND_LAST) ? '0 : b_q + 1'b1;
            end
          end
          S_EXEC: begin
            if (lat_q == LAT_LAST) begin
              res_q   <= alu.alu_result;
              valid_q <= 1'b1;
              state_q <= S_SHOW;
              lat_q   <= '0;
            end else begin
              lat_q <= lat_q + 1'b1;
            end
          end
          S_SHOW: begin
            if (ev_next) state_q <= S_OP;
          end
          default: state_q <= S_OP;
        endcase
      end
    end
  end

  assign alu.alu_a     = a_q;
  assign alu.alu_b     = b_q;
  assign alu.alu_op    = op_q;
  assign alu.alu_start = start_q;
  assign result_q      = res_q;
  assign result_valid  = valid_q;
  assign edit_field    = edit_field_of(state_q);
  assign state_o       = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with DEBOUNCE_CYCLES=4, ALU_LATENCY=2 and
// an a+b ALU. A reference model predicts every output each cycle; directed
// literal checks pin both the DUT and the model at key points.
module tb_alu_sequencer;

  localparam int DEB     = 4;
  localparam int OPC     = 5;
  localparam int OMAX    = 10;
  localparam int LAT     = 2;
  localparam int HOLD    = 8;
  localparam int GAP     = 8;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic [3:0] KEY;
  logic [7:0] result_q;
  logic       result_valid;
  logic [1:0] edit_field;
  logic [2:0] state_o;

  alu_sequencer_if bus ();

  assign bus.alu_result = bus.alu_a + bus.alu_b;

  alu_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .OP_COUNT       (OPC),
    .OPERAND_MAX    (OMAX),
    .ALU_LATENCY    (LAT)
  ) dut (
    .CLOCK_50    (clk),
    .RESET_N     (RESET_N),
    .KEY         (KEY),
    .alu         (bus),
    .result_q    (result_q),
    .result_valid(result_valid),
    .edit_field  (edit_field),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Keys: a 2-stage delayed view of the raw level (released during reset);
  // a level is accepted after DEB consecutive differing samples; an accepted
  // press acts on the FSM at the following edge.
  int       m_state, m_op, m_a, m_b, m_res, m_left;
  int       m_valid, m_start;
  logic [2:0] m_sy1, m_sy2, m_acc, m_ev;
  int       m_run [3];
  bit       m_live = 0;

  always @(posedge clk) begin
    if (!RESET_N) begin
      m_state = 0; m_op = 0; m_a = 0; m_b = 0; m_res = 0; m_left = 0;
      m_valid = 0; m_start = 0;
      m_sy1 = '1; m_sy2 = '1; m_acc = '1; m_ev = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
    end else begin
      m_start = 0;
      if (m_ev[2]) begin
        m_state = 0;
        m_valid = 0;
      end else begin
        case (m_state)
          0: if (m_ev[1]) m_state = 1; else if (m_ev[0]) m_op = (m_op + 1) % OPC;
          1: if (m_ev[1]) m_state = 2; else if (m_ev[0]) m_a = (m_a + 1) % (OMAX + 1);
          2: if (m_ev[1]) begin
               m_state = 3; m_start = 1; m_valid = 0; m_left = LAT;
             end else if (m_ev[0]) m_b = (m_b + 1) % (OMAX + 1);
          3: begin
               m_left--;
               if (m_left == 0) begin
                 m_res = (m_a + m_b) % 256; m_valid = 1; m_state = 4;
               end
             end
          default: if (m_ev[1]) m_state = 0;
        endcase
      end
      for (int i = 0; i < 3; i++) begin
        m_ev[i] = 1'b0;
        if (m_sy2[i] != m_acc[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_acc[i] = m_sy2[i];
            m_run[i] = 0;
            m_ev[i]  = ~m_sy2[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_sy2 = m_sy1;
      m_sy1 = KEY[2:0];
    end
    m_live = 1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("cyc_state",  state_o,       m_state);
      check("cyc_op",     bus.alu_op,    m_op);
      check("cyc_a",      bus.alu_a,     m_a);
      check("cyc_b",      bus.alu_b,     m_b);
      check("cyc_start",  bus.alu_start, m_start);
      check("cyc_valid",  result_valid,  m_valid);
      check("cyc_result", result_q,      m_res);
      check("cyc_edit",   edit_field,    (m_state >= 3) ? 3 : m_state);
    end
  end

  // ---------------- event monitor ----------------
  int   cyc = 0, start_cycles = 0, start_cyc = 0, valid_cyc = 0, valid_rises = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.alu_start === 1'b1) begin
      start_cycles++;
      start_cyc = cyc;
    end
    if (result_valid === 1'b1 && prev_valid !== 1'b1) begin
      valid_rises++;
      valid_cyc = cyc;
    end
    prev_valid = result_valid;
  end

  // ---------------- stimulus ----------------
  task automatic press(logic [3:0] mask);
    @(negedge clk);
    KEY = 4'hF & ~mask;
    repeat (HOLD) @(negedge clk);
    KEY = 4'hF;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic wait_state(int s, int limit);
    int n = 0;
    while (state_o !== 3'(s) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", state_o, s);
  endtask

  int exp_seq [7] = '{1, 2, 3, 4, 0, 1, 2};
  int sc, vr;

  initial begin
    RESET_N = 1'b0;
    KEY     = 4'hE;
    // 1: reset with inc held, release together with reset
    repeat (3) @(negedge clk);
    KEY     = 4'hF;
    RESET_N = 1'b1;
    repeat (10) @(negedge clk);
    check("t1_op",    bus.alu_op,   0);
    check("t1_state", state_o,      0);
    check("t1_valid", result_valid, 0);

    // 2: op wraps after OP_COUNT-1; short glitch ignored
    for (int i = 0; i < 7; i++) begin
      press(4'b0001);
      check("t2_op_seq", bus.alu_op, exp_seq[i]);
    end
    @(negedge clk);
    KEY = 4'hE;
    repeat (2) @(negedge clk);
    KEY = 4'hF;
    repeat (10) @(negedge clk);
    check("t2_glitch_op", bus.alu_op, 2);
    check("t2_model_op",  m_op,       2);

    // 3: full run, b wraps after 10
    press(4'b0010);
    repeat (3) press(4'b0001);
    press(4'b0010);
    repeat (11) press(4'b0001);
    press(4'b0010);
    check("t3_a",          bus.alu_a,    3);
    check("t3_b",          bus.alu_b,    0);
    check("t3_result",     result_q,     3);
    check("t3_valid",      result_valid, 1);
    check("t3_state",      state_o,      4);
    check("t3_edit",       edit_field,   3);
    check("t3_start_cnt",  start_cycles, 1);
    check("t3_latency",    valid_cyc - start_cyc, 2);
    check("t3_model_res",  m_res,        3);

    // 4: abort during S_EXEC
    press(4'b0010);
    check("t4_show_next_state", state_o, 0);
    check("t4_valid_held",      result_valid, 1);
    press(4'b0010);
    press(4'b0010);
    vr = valid_rises;
    @(negedge clk);
    KEY = 4'b1101;
    @(negedge clk);
    KEY = 4'b1001;
    repeat (HOLD) @(negedge clk);
    KEY = 4'hF;
    repeat (GAP) @(negedge clk);
    check("t4_state",     state_o,      0);
    check("t4_valid",     result_valid, 0);
    check("t4_result",    result_q,     3);
    check("t4_a",         bus.alu_a,    3);
    check("t4_b",         bus.alu_b,    0);
    check("t4_start_cnt", start_cycles, 2);
    check("t4_no_result", valid_rises,  vr);

    // 5: next+inc same cycle in S_A; abort+next same cycle in S_B
    press(4'b0010);
    press(4'b0011);
    check("t5_state_b", state_o,   2);
    check("t5_a_kept",  bus.alu_a, 3);
    sc = start_cycles;
    press(4'b0110);
    check("t5_state_op", state_o,      0);
    check("t5_no_start", start_cycles, sc);

    // 6: reset while executing
    press(4'b0010);
    press(4'b0010);
    vr = valid_rises;
    @(negedge clk);
    KEY = 4'b1101;
    wait_state(3, 20);
    RESET_N = 1'b0;
    @(negedge clk);
    check("t6_state",  state_o,       0);
    check("t6_op",     bus.alu_op,    0);
    check("t6_a",      bus.alu_a,     0);
    check("t6_b",      bus.alu_b,     0);
    check("t6_result", result_q,      0);
    check("t6_valid",  result_valid,  0);
    check("t6_start",  bus.alu_start, 0);
    check("t6_edit",   edit_field,    0);
    KEY = 4'hF;
    repeat (2) @(negedge clk);
    RESET_N = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_post_state", state_o,     0);
    check("t6_no_capture", valid_rises, vr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
